spmm_lane_scheduler: RTL and testbench

Parametrised successor of the two-lane CSR scheduler. It multiplies a sparse input matrix, streamed as CSR nonzeros, by a dense weight matrix, computing NUM_PE output columns per pass. Each pass has two phases: first it buffers NUM_PE weight columns, then it streams the nonzeros into internal per-lane MAC accumulators and emits one output row per completed input row. It sits between the CSR input fetcher / weight loader and the output writer, and replaces the external-PE handshake with internal accumulation plus ready/valid flow control.

---
 rtl/spmm_lane_scheduler_if.sv | 45 ++++
 rtl/spmm_lane_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_spmm_lane_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spmm_lane_scheduler_if.sv
// Stream bundle for spmm_lane_scheduler: weight words in, CSR nonzeros in, result rows out.
// The scheduler connects through the slave modport; its environment uses master.
interface spmm_lane_scheduler_if #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40,
   parameter int KW     = 5,
   parameter int NUM_PE = 4,
   parameter int ROW_W  = 7,
   parameter int COL_W  = 3
);
   logic                    w_valid;
   logic                    w_ready;
   logic [DATA_W-1:0]       w_data;

   logic                    s_valid;
   logic                    s_ready;
   logic [DATA_W-1:0]       s_data;
   logic [ROW_W-1:0]        s_row;
   logic [KW-1:0]           s_col;
   logic                    s_last;

   logic                    o_valid;
   logic                    o_ready;
   logic [ROW_W-1:0]        o_row;
   logic [COL_W-1:0]        o_col_base;
   logic [NUM_PE*ACC_W-1:0] o_result;

   modport slave (
      input  w_valid, w_data,
      output w_ready,
      input  s_valid, s_data, s_row, s_col, s_last,
      output s_ready,
      output o_valid, o_row, o_col_base, o_result,
      input  o_ready
   );

   modport master (
      output w_valid, w_data,
      input  w_ready,
      output s_valid, s_data, s_row, s_col, s_last,
      input  s_ready,
      input  o_valid, o_row, o_col_base, o_result,
      output o_ready
   );
endinterface

// File: rtl/spmm_lane_scheduler.sv
// CSR sparse x dense weight scheduler: each pass buffers NUM_PE weight columns, then
// accumulates streamed nonzeros in per-lane MACs and emits one result row per input row.
module spmm_lane_scheduler #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40,
   parameter int K      = 32,
   parameter int KW     = 5,
   parameter int NUM_PE = 4,
   parameter int N_COLS = 8,
   parameter int ROW_W  = 7,
   parameter int COL_W  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   spmm_lane_scheduler_if.slave bus,
   output logic                 busy,
   output logic                 done
);
   localparam int LW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_LAST, S_FLUSH, S_DONE} state_t;

   state_t                               state_q, state_d;
   logic [LW-1:0]                        w_lane_q, w_lane_d;
   logic [KW-1:0]                        w_k_q, w_k_d;
   logic [COL_W-1:0]                     col_base_q, col_base_d;
   logic [ROW_W-1:0]                     cur_row_q, cur_row_d;
   logic                                 have_row_q, have_row_d;
   logic [NUM_PE-1:0][K-1:0][DATA_W-1:0] wbuf_q, wbuf_d;
   logic [NUM_PE-1:0][ACC_W-1:0]         acc_q, acc_d;
   logic                                 o_valid_q, o_valid_d;
   logic [ROW_W-1:0]                     o_row_q, o_row_d;
   logic [COL_W-1:0]                     o_col_base_q, o_col_base_d;
   logic [NUM_PE*ACC_W-1:0]              o_result_q, o_result_d;

   logic [NUM_PE-1:0][DATA_W-1:0]        wt;
   logic signed [2*DATA_W-1:0]           mul [NUM_PE];
   logic [NUM_PE-1:0][ACC_W-1:0]         prod;
   logic                                 slot_free;
   logic                                 row_change;
   logic [COL_W:0]                       col_next;
   logic                                 w_ready;
   logic                                 s_ready;

   assign slot_free  = !o_valid_q || bus.o_ready;
   assign row_change = have_row_q && (bus.s_row != cur_row_q);
   assign col_next   = {1'b0, col_base_q} + (COL_W+1)'(NUM_PE);

   // Column select is a compare per buffered row, so s_col >= K matches nothing and yields 0.
   always_comb begin
      for (int l = 0; l < NUM_PE; l++) begin
         wt[l] = '0;
         for (int k = 0; k < K; k++) begin
            if (bus.s_col == KW'(k)) wt[l] = wbuf_q[l][k];
         end
         mul[l]  = (2*DATA_W)'($signed(bus.s_data)) * (2*DATA_W)'($signed(wt[l]));
         prod[l] = ACC_W'(mul[l]);
      end
   end

   always_comb begin
      // NOTE: every _d starts from its _q so no branch leaves a signal unassigned (no latches).
      state_d      = state_q;
      w_lane_d     = w_lane_q;
      w_k_d        = w_k_q;
      col_base_d   = col_base_q;
      cur_row_d    = cur_row_q;
      have_row_d   = have_row_q;
      wbuf_d       = wbuf_q;
      acc_d        = acc_q;
      o_valid_d    = o_valid_q && !bus.o_ready;
      o_row_d      = o_row_q;
      o_col_base_d = o_col_base_q;
      o_result_d   = o_result_q;
      w_ready      = 1'b0;
      s_ready      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_LOAD;
               col_base_d = '0;
               w_lane_d   = '0;
               w_k_d      = '0;
               have_row_d = 1'b0;
            end
         end
         S_LOAD: begin
            w_ready = 1'b1;
            if (bus.w_valid) begin
               for (int l = 0; l < NUM_PE; l++) begin
                  for (int k = 0; k < K; k++) begin
                     if (w_lane_q == LW'(l) && w_k_q == KW'(k)) wbuf_d[l][k] = bus.w_data;
                  end
               end
               if (w_k_q == KW'(K-1)) begin
                  w_k_d = '0;
                  if (w_lane_q == LW'(NUM_PE-1)) begin
                     w_lane_d = '0;
                     state_d  = S_RUN;
                  end else begin
                     w_lane_d = w_lane_q + LW'(1);
                  end
               end else begin
                  w_k_d = w_k_q + KW'(1);
               end
            end
         end
         S_RUN: begin
            s_ready = slot_free;
            if (bus.s_valid && slot_free) begin
               cur_row_d = bus.s_row;
               if (row_change) begin
                  o_valid_d    = 1'b1;
                  o_row_d      = cur_row_q;
                  o_col_base_d = col_base_q;
                  o_result_d   = acc_q;
                  acc_d        = prod;
                  if (bus.s_last) state_d = S_LAST;
               end else begin
                  for (int l = 0; l < NUM_PE; l++) begin
                     acc_d[l] = have_row_q ? acc_q[l] + prod[l] : prod[l];
                  end
                  have_row_d = 1'b1;
                  if (bus.s_last) begin
                     o_valid_d    = 1'b1;
                     o_row_d      = bus.s_row;
                     o_col_base_d = col_base_q;
                     o_result_d   = acc_d;
                     have_row_d   = 1'b0;
                     state_d      = S_FLUSH;
                  end
               end
            end
         end
         // A final nonzero that opened a new row: emit that one-element row once the slot frees.
         S_LAST: begin
            if (slot_free) begin
               o_valid_d    = 1'b1;
               o_row_d      = cur_row_q;
               o_col_base_d = col_base_q;
               o_result_d   = acc_q;
               have_row_d   = 1'b0;
               state_d      = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (!o_valid_q) begin
               col_base_d = col_next[COL_W-1:0];
               state_d    = (col_next == (COL_W+1)'(N_COLS)) ? S_DONE : S_LOAD;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use nonblocking assignments only, so all flops sample together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         w_lane_q     <= '0;
         w_k_q        <= '0;
         col_base_q   <= '0;
         cur_row_q    <= '0;
         have_row_q   <= 1'b0;
         // NOTE: the weight buffer is a flop array, not a RAM macro, so it is cleared on reset.
         wbuf_q       <= '0;
         acc_q        <= '0;
         o_valid_q    <= 1'b0;
         o_row_q      <= '0;
         o_col_base_q <= '0;
         o_result_q   <= '0;
      end else begin
         state_q      <= state_d;
         w_lane_q     <= w_lane_d;
         w_k_q        <= w_k_d;
         col_base_q   <= col_base_d;
         cur_row_q    <= cur_row_d;
         have_row_q   <= have_row_d;
         wbuf_q       <= wbuf_d;
         acc_q        <= acc_d;
         o_valid_q    <= o_valid_d;
         o_row_q      <= o_row_d;
         o_col_base_q <= o_col_base_d;
         o_result_q   <= o_result_d;
      end
   end

   assign bus.w_ready    = w_ready;
   assign bus.s_ready    = s_ready;
   assign bus.o_valid    = o_valid_q;
   assign bus.o_row      = o_row_q;
   assign bus.o_col_base = o_col_base_q;
   assign bus.o_result   = o_result_q;
   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_DONE);
endmodule

// File: tb/tb_spmm_lane_scheduler.sv
// Directed bench for spmm_lane_scheduler (2 lanes, 4 columns, K=4, 20-bit accumulators):
// two-pass jobs against hand-computed rows, backpressure, wraparound, edges and mid-run reset.
module tb_spmm_lane_scheduler;
   localparam int DATA_W = 16;
   localparam int ACC_W  = 20;
   localparam int K      = 4;
   localparam int KW     = 3;
   localparam int NUM_PE = 2;
   localparam int N_COLS = 4;
   localparam int ROW_W  = 7;
   localparam int COL_W  = 3;

   typedef struct {
      int row;
      int col;
      int val;
      bit last;
   } nz_t;

   typedef struct {
      int row;
      int cb;
      int l0;
      int l1;
   } out_t;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic start = 1'b0;
   logic busy;
   logic done;

   int   total      = 0;
   int   bad        = 0;
   int   done_cnt   = 0;
   int   done_base  = 0;
   int   busy_gap   = 0;
   bit   job_active = 1'b0;
   int   w_sel      = 0;

   nz_t  nz_q[$];
   out_t exp_q[$];
   out_t got_q[$];

   // Weight set 0, column-major: col0 = 1,2,3,4  col1 = 5,6,7,8  col2 = 1,0,-1,2  col3 = 0,3,0,-2
   int   w_set_a [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 1, 0, -1, 2, 0, 3, 0, -2};

   spmm_lane_scheduler_if #(
      .DATA_W(DATA_W), .ACC_W(ACC_W), .KW(KW), .NUM_PE(NUM_PE), .ROW_W(ROW_W), .COL_W(COL_W)
   ) bus ();

   spmm_lane_scheduler #(
      .DATA_W(DATA_W), .ACC_W(ACC_W), .K(K), .KW(KW), .NUM_PE(NUM_PE),
      .N_COLS(N_COLS), .ROW_W(ROW_W), .COL_W(COL_W)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bus   (bus),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic check(input string nm, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   function automatic int lane_val(input logic [NUM_PE*ACC_W-1:0] r, input int l);
      logic signed [ACC_W-1:0] v;
      v = r[l*ACC_W +: ACC_W];
      return int'(v);
   endfunction

   function automatic int weight(input int col, input int row);
      if (w_sel == 0) return w_set_a[col*K + row];
      return 32767;
   endfunction

   // Output-side monitor: records consumed rows, done pulses and any busy gap inside a job.
   always @(negedge clk) begin
      out_t o;
      if (bus.o_valid && bus.o_ready) begin
         o.row = int'(bus.o_row);
         o.cb  = int'(bus.o_col_base);
         o.l0  = lane_val(bus.o_result, 0);
         o.l1  = lane_val(bus.o_result, 1);
         got_q.push_back(o);
      end
      if (done) done_cnt++;
      if (job_active && !busy) busy_gap++;
   end

   task automatic add_nz(input int row, input int col, input int val, input bit last);
      nz_t z;
      z.row = row; z.col = col; z.val = val; z.last = last;
      nz_q.push_back(z);
   endtask

   task automatic add_exp(input int row, input int cb, input int l0, input int l1);
      out_t o;
      o.row = row; o.cb = cb; o.l0 = l0; o.l1 = l1;
      exp_q.push_back(o);
   endtask

   task automatic send_w(input int d);
      int n = 0;
      bus.w_valid = 1'b1;
      bus.w_data  = DATA_W'(d);
      while (n < 40) begin
         @(negedge clk);
         if (bus.w_ready) break;
         n++;
      end
      if (n >= 40) begin
         total++; bad++;
         $display("FAIL w_handshake: w_ready low for %0d cycles, required high", n);
      end else begin
         @(posedge clk); #1;
      end
      bus.w_valid = 1'b0;
   endtask

   task automatic send_s(input nz_t z);
      int n = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = DATA_W'(z.val);
      bus.s_row   = ROW_W'(z.row);
      bus.s_col   = KW'(z.col);
      bus.s_last  = z.last;
      while (n < 40) begin
         @(negedge clk);
         if (bus.s_ready) break;
         n++;
      end
      if (n >= 40) begin
         total++; bad++;
         $display("FAIL s_handshake: s_ready low for %0d cycles, required high", n);
      end else begin
         @(posedge clk); #1;
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic load_pass(input int p);
      for (int c = 0; c < NUM_PE; c++)
         for (int r = 0; r < K; r++)
            send_w(weight(p*NUM_PE + c, r));
   endtask

   task automatic run_nz();
      foreach (nz_q[i]) send_s(nz_q[i]);
   endtask

   task automatic start_job();
      start = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
      done_base  = done_cnt;
      busy_gap   = 0;
      job_active = 1'b1;
      got_q.delete();
   endtask

   task automatic finish_job(input string tag);
      int n = 0;
      while (n < 400 && done_cnt == done_base) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt == done_base) begin
         total++; bad++;
         $display("FAIL %s_done_wait: no done within %0d cycles", tag, n);
      end
      job_active = 1'b0;
      repeat (3) @(negedge clk);
      check({tag, "_done_pulses"}, done_cnt - done_base, 1);
      check({tag, "_busy_after"}, busy, 0);
      check({tag, "_busy_gaps"}, busy_gap, 0);
      check({tag, "_rows"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("%s_o%0d_row", tag, i), got_q[i].row, exp_q[i].row);
         check($sformatf("%s_o%0d_colbase", tag, i), got_q[i].cb, exp_q[i].cb);
         check($sformatf("%s_o%0d_lane0", tag, i), got_q[i].l0, exp_q[i].l0);
         check($sformatf("%s_o%0d_lane1", tag, i), got_q[i].l1, exp_q[i].l1);
      end
      @(posedge clk); #1;
   endtask

   task automatic setup_basic();
      nz_q.delete(); exp_q.delete();
      w_sel = 0;
      add_nz(0, 1, 2, 1'b0);
      add_nz(0, 3, 1, 1'b0);
      add_nz(2, 0, -3, 1'b1);
      add_exp(0, 0, 8, 20);
      add_exp(2, 0, -3, -15);
      add_exp(0, 2, 2, 4);
      add_exp(2, 2, -3, 0);
   endtask

   task automatic run_plain(input string tag);
      start_job();
      for (int p = 0; p < N_COLS / NUM_PE; p++) begin
         load_pass(p);
         run_nz();
      end
      finish_job(tag);
   endtask

   initial begin
      bus.w_valid = 1'b0; bus.w_data = '0;
      bus.s_valid = 1'b0; bus.s_data = '0; bus.s_row = '0; bus.s_col = '0; bus.s_last = 1'b0;
      bus.o_ready = 1'b1;

      repeat (2) @(negedge clk);
      check("rst_w_ready", bus.w_ready, 0);
      check("rst_s_ready", bus.s_ready, 0);
      check("rst_o_valid", bus.o_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_o_row", bus.o_row, 0);
      check("rst_o_col_base", bus.o_col_base, 0);
      check("rst_o_result", bus.o_result, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Two passes, row change on the last nonzero in each pass.
      setup_basic();
      run_plain("basic");

      // Backpressure: row 0 stalls in the slot; s_col = 4 (= K) contributes nothing.
      nz_q.delete(); exp_q.delete();
      w_sel = 0;
      add_nz(0, 0, 1, 1'b0);
      add_nz(1, 4, 5, 1'b0);
      add_nz(1, 2, 2, 1'b0);
      add_nz(2, 3, 1, 1'b1);
      add_exp(0, 0, 1, 5);
      add_exp(1, 0, 6, 14);
      add_exp(2, 0, 4, 8);
      add_exp(0, 2, 1, 0);
      add_exp(1, 2, -2, 0);
      add_exp(2, 2, 2, -2);
      bus.o_ready = 1'b0;
      start_job();
      load_pass(0);
      send_s(nz_q[0]);
      send_s(nz_q[1]);
      repeat (3) @(negedge clk);
      check("bp_s_ready_low", bus.s_ready, 0);
      check("bp_o_valid_held", bus.o_valid, 1);
      check("bp_o_row_held", bus.o_row, 0);
      check("bp_lane1_held", lane_val(bus.o_result, 1), 5);
      check("bp_nothing_consumed", got_q.size(), 0);
      @(posedge clk); #1;
      bus.o_ready = 1'b1;
      send_s(nz_q[2]);
      send_s(nz_q[3]);
      load_pass(1);
      run_nz();
      finish_job("backpressure");

      // Wraparound: 17 x 32767*32767 in one row wraps mod 2^20 to -65519; start during RUN ignored.
      nz_q.delete(); exp_q.delete();
      w_sel = 1;
      for (int i = 0; i < 17; i++) add_nz(5, 1, 32767, (i == 16));
      add_exp(5, 0, -65519, -65519);
      add_exp(5, 2, -65519, -65519);
      start_job();
      load_pass(0);
      for (int i = 0; i < 17; i++) begin
         send_s(nz_q[i]);
         if (i == 8) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
      end
      load_pass(1);
      run_nz();
      finish_job("wrap");

      // Single-nonzero matrix: exactly one row per pass.
      nz_q.delete(); exp_q.delete();
      w_sel = 0;
      add_nz(3, 2, -1, 1'b1);
      add_exp(3, 0, -3, -7);
      add_exp(3, 2, 1, 0);
      run_plain("single");

      // Reset while a row is pending in the slot and the last row waits behind it.
      nz_q.delete(); exp_q.delete();
      w_sel = 0;
      add_nz(4, 0, 1, 1'b0);
      add_nz(6, 2, 2, 1'b1);
      bus.o_ready = 1'b0;
      start_job();
      load_pass(0);
      send_s(nz_q[0]);
      send_s(nz_q[1]);
      @(negedge clk);
      check("mr_pending_valid", bus.o_valid, 1);
      check("mr_pending_row", bus.o_row, 4);
      #2;
      job_active = 1'b0;
      rst = 1'b0;
      #1;
      check("mr_o_valid", bus.o_valid, 0);
      check("mr_s_ready", bus.s_ready, 0);
      check("mr_w_ready", bus.w_ready, 0);
      check("mr_busy", busy, 0);
      check("mr_done", done, 0);
      check("mr_o_row", bus.o_row, 0);
      check("mr_o_col_base", bus.o_col_base, 0);
      check("mr_o_result", bus.o_result, 0);
      @(negedge clk);
      rst = 1'b1;
      bus.o_ready = 1'b1;
      @(posedge clk); #1;
      check("mr_no_output", got_q.size(), 0);
      check("mr_no_done", done_cnt - done_base, 0);

      setup_basic();
      run_plain("after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
